// File: rtl/inst_cache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: default geometry,
// FSM encoding and address field extraction helpers.
package inst_cache_pkg;

  localparam int unsigned LINE_NUM_DEF   = 16;
  localparam int unsigned LINE_WORDS_DEF = 4;
  localparam int unsigned ADDR_WIDTH_DEF = 32;

  localparam int unsigned OFS_BITS = $clog2(LINE_WORDS_DEF);
  localparam int unsigned IDX_BITS = $clog2(LINE_NUM_DEF);
  localparam int unsigned TAG_BITS = ADDR_WIDTH_DEF - OFS_BITS - IDX_BITS - 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Extract a `width`-bit field starting at bit `lsb` of a byte address.
  function automatic logic [63:0] addr_field(input logic [63:0] addr,
                                             input int unsigned lsb,
                                             input int unsigned width);
    logic [63:0] mask;
    mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (addr >> lsb) & mask;
  endfunction

  function automatic int unsigned idx_lsb(input int unsigned ofs_bits);
    return ofs_bits + 2;
  endfunction

  function automatic int unsigned tag_lsb(input int unsigned ofs_bits,
                                          input int unsigned idx_bits);
    return ofs_bits + idx_bits + 2;
  endfunction

endpackage

// File: rtl/inst_cache_store.sv
// Tag, valid and data arrays of the instruction cache: combinational read,
// single-word write, whole-array valid clear and per-line valid set.
module inst_cache_store
  import inst_cache_pkg::*;
#(
  parameter int unsigned IDX_W = IDX_BITS,
  parameter int unsigned OFS_W = OFS_BITS,
  parameter int unsigned TAG_W = TAG_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] i_rd_idx,
  input  logic [OFS_W-1:0] i_rd_ofs,
  output logic             o_rd_valid,
  output logic [TAG_W-1:0] o_rd_tag,
  output logic [31:0]      o_rd_word,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [OFS_W-1:0] i_wr_ofs,
  input  logic [31:0]      i_wr_data,
  input  logic             i_tag_we,
  input  logic [TAG_W-1:0] i_wr_tag,
  input  logic             i_set_valid,
  input  logic             i_clr_all
);

  localparam int unsigned LINE_NUM   = 1 << IDX_W;
  localparam int unsigned LINE_WORDS = 1 << OFS_W;

  logic [LINE_NUM-1:0] r_valid;
  logic [TAG_W-1:0]    r_tag  [LINE_NUM];
  logic [31:0]         r_data [LINE_NUM][LINE_WORDS];

  // Valid bits: clear-all wins over a set in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
    end else if (i_clr_all) begin
      r_valid <= '0;
    end else if (i_set_valid) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  // Payload arrays carry no reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_data[i_wr_idx][i_wr_ofs] <= i_wr_data;
    end
    if (i_tag_we) begin
      r_tag[i_wr_idx] <= i_wr_tag;
    end
  end

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_word  = r_data[i_rd_idx][i_rd_ofs];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache: same-cycle hits, miss refills a
// whole line through a req/rvalid burst, with flush and line poisoning.
module inst_cache
  import inst_cache_pkg::*;
#(
  parameter int unsigned LINE_NUM   = LINE_NUM_DEF,
  parameter int unsigned LINE_WORDS = LINE_WORDS_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_ren,
  input  logic [ADDR_WIDTH-1:0] inst_addr,
  output logic [31:0]           inst_data,
  output logic                  inst_stall,
  input  logic                  flush,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_rvalid,
  input  logic [31:0]           mem_din
);

  localparam int unsigned OFS_W = $clog2(LINE_WORDS);
  localparam int unsigned IDX_W = $clog2(LINE_NUM);
  localparam int unsigned TAG_W = ADDR_WIDTH - OFS_W - IDX_W - 2;

  state_e                r_state;
  state_e                w_state_nxt;
  logic [OFS_W-1:0]      r_cnt;
  logic [OFS_W-1:0]      w_cnt_nxt;
  logic                  r_mem_req;
  logic                  w_mem_req_nxt;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [ADDR_WIDTH-1:0] w_mem_addr_nxt;
  logic [IDX_W-1:0]      r_ref_idx;
  logic [TAG_W-1:0]      r_ref_tag;
  logic                  r_poison;
  logic                  w_poison_nxt;

  logic [OFS_W-1:0]      w_ofs;
  logic [IDX_W-1:0]      w_idx;
  logic [TAG_W-1:0]      w_tag;
  logic [ADDR_WIDTH-1:0] w_line_base;
  logic                  w_rd_valid;
  logic [TAG_W-1:0]      w_rd_tag;
  logic [31:0]           w_rd_word;
  logic                  w_hit;
  logic                  w_idle_hit;
  logic                  w_start;
  logic                  w_wr_en;
  logic                  w_last;
  logic                  w_set_valid;

  assign w_ofs = OFS_W'(addr_field(64'(inst_addr), 2, OFS_W));
  assign w_idx = IDX_W'(addr_field(64'(inst_addr), idx_lsb(OFS_W), IDX_W));
  assign w_tag = TAG_W'(addr_field(64'(inst_addr), tag_lsb(OFS_W, IDX_W), TAG_W));
  assign w_line_base = {w_tag, w_idx, {(OFS_W + 2){1'b0}}};

  inst_cache_store #(
    .IDX_W (IDX_W),
    .OFS_W (OFS_W),
    .TAG_W (TAG_W)
  ) u_store (
    .clk         (clk),
    .rst         (rst),
    .i_rd_idx    (w_idx),
    .i_rd_ofs    (w_ofs),
    .o_rd_valid  (w_rd_valid),
    .o_rd_tag    (w_rd_tag),
    .o_rd_word   (w_rd_word),
    .i_wr_en     (w_wr_en),
    .i_wr_idx    (r_ref_idx),
    .i_wr_ofs    (r_cnt),
    .i_wr_data   (mem_din),
    .i_tag_we    (w_last),
    .i_wr_tag    (r_ref_tag),
    .i_set_valid (w_set_valid),
    .i_clr_all   (flush)
  );

  assign w_hit      = inst_ren & w_rd_valid & (w_rd_tag == w_tag);
  assign w_idle_hit = (r_state == ST_IDLE) & w_hit;

  // Stall is gated by reset so a held fetch does not stall while in reset.
  assign inst_stall = rst & inst_ren & ~w_idle_hit;
  assign inst_data  = w_idle_hit ? w_rd_word : 32'd0;
  assign mem_req    = r_mem_req;
  assign mem_addr   = r_mem_addr;

  // A flush landing on the last refill word must also leave the line invalid.
  assign w_set_valid = w_last & ~r_poison & ~flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_ref_idx  <= '0;
      r_ref_tag  <= '0;
      r_poison   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_mem_req  <= w_mem_req_nxt;
      r_mem_addr <= w_mem_addr_nxt;
      r_poison   <= w_poison_nxt;
      if (w_start) begin
        r_ref_idx <= w_idx;
        r_ref_tag <= w_tag;
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_mem_req_nxt  = r_mem_req;
    w_mem_addr_nxt = r_mem_addr;
    w_poison_nxt   = r_poison;
    w_start        = 1'b0;
    w_wr_en        = 1'b0;
    w_last         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (inst_ren && !w_hit) begin
          w_state_nxt    = ST_REFILL;
          w_mem_req_nxt  = 1'b1;
          w_mem_addr_nxt = w_line_base;
          w_poison_nxt   = 1'b0;
          w_start        = 1'b1;
        end
      end
      ST_REFILL: begin
        if (flush) begin
          w_poison_nxt = 1'b1;
        end
        if (mem_rvalid) begin
          w_wr_en   = 1'b1;
          w_cnt_nxt = r_cnt + OFS_W'(1);
          if (r_cnt == OFS_W'(LINE_WORDS - 1)) begin
            w_last        = 1'b1;
            w_state_nxt   = ST_DONE;
            w_mem_req_nxt = 1'b0;
          end
        end
      end
      ST_DONE: begin
        if (flush) begin
          w_poison_nxt = 1'b1;
        end
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_mem_req_nxt = 1'b0;
        w_cnt_nxt     = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_inst_cache.sv
// Self-checking bench for inst_cache: directed scenarios plus random fetches
// compared against a line-level model of a direct-mapped cache.
module tb_inst_cache;
  import inst_cache_pkg::*;

  logic        clk;
  logic        rst;
  logic        inst_ren;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;
  logic        inst_stall;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_din;

  int n_checks;
  int n_fail;

  bit          mv    [LINE_NUM_DEF];
  logic [31:0] mline [LINE_NUM_DEF];

  inst_cache dut (
    .clk        (clk),
    .rst        (rst),
    .inst_ren   (inst_ren),
    .inst_addr  (inst_addr),
    .inst_data  (inst_data),
    .inst_stall (inst_stall),
    .flush      (flush),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rvalid (mem_rvalid),
    .mem_din    (mem_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Backing instruction memory: fixed image, 0xA0..0xA3 at line 0x40.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = a & ~32'h3;
    if (w >= 32'h40 && w <= 32'h4C) return 32'hA0 + ((w - 32'h40) >> 2);
    return (w * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  function automatic logic [31:0] line_of(input logic [31:0] a);
    return a >> (OFS_BITS + 2);
  endfunction

  function automatic logic [IDX_BITS-1:0] slot_of(input logic [31:0] a);
    return IDX_BITS'(line_of(a) % LINE_NUM_DEF);
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return mv[slot_of(a)] && (mline[slot_of(a)] == line_of(a));
  endfunction

  task automatic model_clear();
    foreach (mv[i]) mv[i] = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Fetch until the word is delivered. mode 0: rvalid every cycle,
  // 1: pattern 1,0,0,1,1,0,1, 2: random gaps. flush_word n>0 pulses flush
  // together with the n-th refill word of the first refill.
  task automatic fetch(input logic [31:0] a, input int mode, input int flush_word);
    logic [31:0]          base;
    logic [IDX_BITS-1:0]  slot;
    int                   got, k, fw;
    bit                   v, poisoned, done;
    base = line_of(a) << (OFS_BITS + 2);
    slot = slot_of(a);
    fw   = flush_word;
    done = 1'b0;
    inst_ren  = 1'b1;
    inst_addr = a;
    for (int it = 0; it < 3 && !done; it++) begin
      @(negedge clk);
      if (m_hit(a)) begin
        check("hit_stall", 32'(inst_stall), 32'd0);
        check("hit_data", inst_data, mem_word(a));
        done = 1'b1;
      end else begin
        check("miss_stall", 32'(inst_stall), 32'd1);
        check("miss_data", inst_data, 32'd0);
        check("miss_req_t", 32'(mem_req), 32'd0);
        cyc();
        got = 0;
        k = 0;
        poisoned = 1'b0;
        while (got < int'(LINE_WORDS_DEF)) begin
          case (mode)
            0:       v = 1'b1;
            1:       v = (k == 0 || k == 3 || k == 4 || k >= 6);
            default: v = ($urandom_range(0, 2) != 0);
          endcase
          if (k >= 24) v = 1'b1;
          mem_rvalid = v;
          mem_din    = v ? mem_word(base + 32'(4 * got)) : $urandom();
          flush      = v && (fw == got + 1);
          if (flush) poisoned = 1'b1;
          @(negedge clk);
          check("refill_req", 32'(mem_req), 32'd1);
          check("refill_addr", mem_addr, base);
          check("refill_stall", 32'(inst_stall), 32'd1);
          if (v) got++;
          k++;
          cyc();
        end
        flush      = 1'b0;
        mem_rvalid = 1'($urandom_range(0, 1));
        mem_din    = $urandom();
        @(negedge clk);
        check("done_stall", 32'(inst_stall), 32'd1);
        check("done_req", 32'(mem_req), 32'd0);
        cyc();
        mem_rvalid = 1'b0;
        if (poisoned) begin
          model_clear();
        end else begin
          mv[slot]    = 1'b1;
          mline[slot] = line_of(a);
        end
        fw = 0;
      end
    end
    check("fetch_done", 32'(done), 32'd1);
    cyc();
    inst_ren = 1'b0;
  endtask

  task automatic flush_idle();
    inst_ren = 1'b0;
    flush    = 1'b1;
    @(negedge clk);
    check("flush_idle_stall", 32'(inst_stall), 32'd0);
    cyc();
    flush = 1'b0;
    model_clear();
  endtask

  initial begin
    logic [31:0] a;
    int          md, fw;
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b0;
    inst_ren   = 1'b1;
    inst_addr  = 32'h40;
    flush      = 1'b0;
    mem_rvalid = 1'b0;
    mem_din    = 32'd0;
    model_clear();

    #12;
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_stall", 32'(inst_stall), 32'd0);
    check("rst_data", inst_data, 32'd0);
    inst_ren = 1'b0;
    rst      = 1'b1;
    cyc();

    // Cold miss then same-line hit.
    fetch(32'h40, 0, 0);
    fetch(32'h4C, 0, 0);

    // Conflict miss on the same index, then the evicted line misses again.
    fetch(32'h140, 0, 0);
    fetch(32'h40, 0, 0);

    // Gapped burst; every word of the line must land in its slot.
    fetch(32'h80, 1, 0);
    fetch(32'h84, 0, 0);
    fetch(32'h88, 0, 0);
    fetch(32'h8C, 0, 0);

    // Lookup in the flush cycle still sees pre-flush valids.
    inst_ren  = 1'b1;
    inst_addr = 32'h44;
    flush     = 1'b1;
    @(negedge clk);
    check("flush_cyc_stall", 32'(inst_stall), 32'd0);
    check("flush_cyc_data", inst_data, 32'hA1);
    cyc();
    flush    = 1'b0;
    inst_ren = 1'b0;
    model_clear();
    fetch(32'h40, 0, 0);

    // Flush mid-refill and on the last word: line ends invalid, re-miss.
    fetch(32'h80, 2, 2);
    fetch(32'hC0, 0, 4);
    fetch(32'h40, 0, 0);

    // Reset after two refill words abandons the burst asynchronously.
    flush_idle();
    inst_ren  = 1'b1;
    inst_addr = 32'h40;
    @(negedge clk);
    check("rstmid_miss", 32'(inst_stall), 32'd1);
    cyc();
    for (int i = 0; i < 2; i++) begin
      mem_rvalid = 1'b1;
      mem_din    = 32'hBAD0_0000 + 32'(i);
      cyc();
    end
    mem_rvalid = 1'b0;
    rst        = 1'b0;
    #1;
    check("rstmid_req", 32'(mem_req), 32'd0);
    check("rstmid_stall", 32'(inst_stall), 32'd0);
    check("rstmid_data", inst_data, 32'd0);
    cyc();
    rst      = 1'b1;
    inst_ren = 1'b0;
    model_clear();
    cyc();
    fetch(32'h40, 0, 0);
    fetch(32'h44, 0, 0);
    fetch(32'h48, 0, 0);
    fetch(32'h4C, 0, 0);

    // No fetch: no stall, no data, no request, stray rvalid ignored.
    for (int i = 0; i < 20; i++) begin
      inst_ren   = 1'b0;
      inst_addr  = $urandom();
      mem_rvalid = 1'($urandom_range(0, 1));
      mem_din    = $urandom();
      @(negedge clk);
      check("noren_stall", 32'(inst_stall), 32'd0);
      check("noren_data", inst_data, 32'd0);
      check("noren_req", 32'(mem_req), 32'd0);
      cyc();
    end
    mem_rvalid = 1'b0;

    // Random fetches over a small address pool to mix hits and conflicts.
    for (int i = 0; i < 80; i++) begin
      a  = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 15) << 4) |
           ($urandom_range(0, 3) << 2);
      md = int'($urandom_range(0, 2));
      fw = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 4)) : 0;
      if ($urandom_range(0, 9) == 0) flush_idle();
      fetch(a, md, fw);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
